mv_result_tx: RTL and testbench



---
 rtl/mv_result_tx.sv | 109 ++++++++++
 tb/tb_mv_result_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mv_result_tx.sv
// Streaming transmitter for one 3-element MAC result, sent c1 first over valid/ready.
// Define MVTX_CKSUM_EN to append a fourth word, c1 ^ c2 ^ c3, to every result.
module mv_result_tx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_valid,
  output logic              cap_ready,
  input  logic [DATA_W-1:0] c1,
  input  logic [DATA_W-1:0] c2,
  input  logic [DATA_W-1:0] c3,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              cap_err
);

`ifdef MVTX_CKSUM_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif
  localparam logic [1:0] LAST_IDX = 2'(NW - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                   state;
  logic [1:0]                   idx;
  logic [NW-1:0][DATA_W-1:0]    active;
  logic [NW-1:0][DATA_W-1:0]    pending;
  logic [NW-1:0][DATA_W-1:0]    new_res;
  logic                         pend_full;
  logic                         cap;
  logic                         hs;
  logic                         last_hs;

  always_comb begin
    new_res    = '0;
    new_res[0] = c1;
    new_res[1] = c2;
    new_res[2] = c3;
`ifdef MVTX_CKSUM_EN
    new_res[3] = c1 ^ c2 ^ c3;
`endif
  end

  assign cap_ready = !pend_full;
  assign cap       = cap_valid && !pend_full;
  assign out_valid = (state == SEND);
  assign out_data  = active[idx];
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign hs        = out_valid && out_ready;
  assign last_hs   = hs && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      cap_err   <= 1'b0;
    end else begin
      if (cap_valid && pend_full)
        cap_err <= 1'b1;

      case (state)
        IDLE: begin
          if (cap) begin
            active <= new_res;
            idx    <= 2'd0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (last_hs) begin
            // pending wins; a capture here is impossible since cap_ready is low
            if (pend_full) begin
              active    <= pending;
              pend_full <= 1'b0;
              idx       <= 2'd0;
            end else if (cap) begin
              active <= new_res;
              idx    <= 2'd0;
            end else begin
              idx   <= 2'd0;
              state <= IDLE;
            end
          end else begin
            if (hs)
              idx <= idx + 2'd1;
            if (cap) begin
              pending   <= new_res;
              pend_full <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mv_result_tx.sv
// Directed bench for mv_result_tx: hand-computed word sequences, stall stability, buffering, reset.
// Follows MVTX_CKSUM_EN so the expected word list matches the build.
module tb_mv_result_tx;

`ifdef MVTX_CKSUM_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cap_valid;
  logic        cap_ready;
  logic [15:0] c1, c2, c3;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        cap_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] got_q[$];
  logic        got_last_q[$];
  logic [15:0] exp_q[$];
  logic        exp_last_q[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  mv_result_tx #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .cap_valid(cap_valid), .cap_ready(cap_ready),
    .c1(c1), .c2(c2), .c3(c3),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .cap_err(cap_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // delivered words and stall stability, observed mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) begin
        chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_last_q.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_result(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    exp_q.push_back(a); exp_last_q.push_back(NW == 3 ? 1'b0 : 1'b0);
    exp_q.push_back(b); exp_last_q.push_back(1'b0);
    exp_q.push_back(c); exp_last_q.push_back(NW == 3);
    if (NW == 4) begin
      exp_q.push_back(a ^ b ^ c);
      exp_last_q.push_back(1'b1);
    end
  endtask

  task automatic set_cap(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    cap_valid = v; c1 = a; c2 = b; c3 = c;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 30 && out_valid; i++) step();
    chk("drain_done", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_word"}, {16'd0, got_q[i]}, {16'd0, exp_q[i]});
      chk({tag, "_last"}, {31'd0, got_last_q[i]}, {31'd0, exp_last_q[i]});
    end
    got_q.delete(); got_last_q.delete();
    exp_q.delete(); exp_last_q.delete();
  endtask

  initial begin
    logic [15:0] w[4];
    logic        rdy_pat[5];
    int          word_at[5];

    reset = 1'b1; out_ready = 1'b0;
    set_cap(1'b0, 16'h0, 16'h0, 16'h0);
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_err", {31'd0, cap_err}, 32'd0);
    chk("rst_ready", {31'd0, cap_ready}, 32'd1);

    // single result, continuous ready
    out_ready = 1'b1;
    set_cap(1'b1, 16'h0001, 16'h0002, 16'h0003);
    step();
    cap_valid = 1'b0;
    w[0] = 16'h0001; w[1] = 16'h0002; w[2] = 16'h0003; w[3] = 16'h0000;
    for (int i = 0; i < NW; i++) begin
      chk("single_valid", {31'd0, out_valid}, 32'd1);
      chk("single_data", {16'd0, out_data}, {16'd0, w[i]});
      chk("single_last", {31'd0, out_last}, (i == NW - 1) ? 32'd1 : 32'd0);
      step();
    end
    chk("single_idle", {31'd0, out_valid}, 32'd0);
    got_q.delete(); got_last_q.delete();

    // stalls: ready pattern 1,0,0,1,1
    rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1; rdy_pat[4] = 1;
    word_at[0] = 0; word_at[1] = 1; word_at[2] = 1; word_at[3] = 1; word_at[4] = 2;
    w[0] = 16'h1234; w[1] = 16'hABCD; w[2] = 16'hFFFF;
    set_cap(1'b1, w[0], w[1], w[2]);
    out_ready = 1'b0;
    step();
    cap_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_ready = rdy_pat[i];
      chk("stall_seq", {16'd0, out_data}, {16'd0, w[word_at[i]]});
      step();
    end
    drain();
    push_result(16'h1234, 16'hABCD, 16'hFFFF);
    check_stream("stall");

    // back-to-back: second capture lands on the last handshake of the first
    out_ready = 1'b1;
    set_cap(1'b1, 16'h0010, 16'h0011, 16'h0012);
    step();
    cap_valid = 1'b0;
    for (int i = 1; i < NW; i++) begin
      chk("b2b_ready", {31'd0, cap_ready}, 32'd1);
      step();
    end
    set_cap(1'b1, 16'h0020, 16'h0021, 16'h0022);
    chk("b2b_ready", {31'd0, cap_ready}, 32'd1);
    step();
    cap_valid = 1'b0;
    for (int i = 0; i < NW; i++) begin
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_ready", {31'd0, cap_ready}, 32'd1);
      step();
    end
    drain();
    push_result(16'h0010, 16'h0011, 16'h0012);
    push_result(16'h0020, 16'h0021, 16'h0022);
    check_stream("b2b");

    // buffering limit: active + pending, third capture dropped
    out_ready = 1'b0;
    set_cap(1'b1, 16'h0A01, 16'h0A02, 16'h0A03);
    step();
    chk("buf_ready1", {31'd0, cap_ready}, 32'd1);
    set_cap(1'b1, 16'h0B01, 16'h0B02, 16'h0B03);
    step();
    chk("buf_ready2", {31'd0, cap_ready}, 32'd0);
    chk("buf_err0", {31'd0, cap_err}, 32'd0);
    set_cap(1'b1, 16'h0C01, 16'h0C02, 16'h0C03);
    step();
    cap_valid = 1'b0;
    chk("buf_err1", {31'd0, cap_err}, 32'd1);
    chk("buf_data", {16'd0, out_data}, 32'h0A01);
    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) begin
      chk("buf_ready_hold", {31'd0, cap_ready}, 32'd0);
      step();
    end
    chk("buf_ready_back", {31'd0, cap_ready}, 32'd1);
    chk("buf_next", {16'd0, out_data}, 32'h0B01);
    drain();
    chk("buf_err_sticky", {31'd0, cap_err}, 32'd1);
    push_result(16'h0A01, 16'h0A02, 16'h0A03);
    push_result(16'h0B01, 16'h0B02, 16'h0B03);
    check_stream("buf");

    // reset while word 1 stalled
    out_ready = 1'b0;
    set_cap(1'b1, 16'h5501, 16'h5502, 16'h5503);
    step();
    cap_valid = 1'b0;
    chk("mid_valid_pre", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_data", {16'd0, out_data}, 32'd0);
    chk("mid_err", {31'd0, cap_err}, 32'd0);
    chk("mid_ready", {31'd0, cap_ready}, 32'd1);
    step();
    reset = 1'b0;
    got_q.delete(); got_last_q.delete();
    set_cap(1'b1, 16'h6601, 16'h6602, 16'h6603);
    step();
    cap_valid = 1'b0;
    chk("mid_restart", {16'd0, out_data}, 32'h6601);
    drain();
    push_result(16'h6601, 16'h6602, 16'h6603);
    check_stream("mid");

    // capture on the last-word handshake with pending empty
    out_ready = 1'b1;
    set_cap(1'b1, 16'h7701, 16'h7702, 16'h7703);
    step();
    cap_valid = 1'b0;
    for (int i = 1; i < NW; i++) step();
    chk("coin_last", {31'd0, out_last}, 32'd1);
    set_cap(1'b1, 16'h8801, 16'h8802, 16'h8803);
    step();
    cap_valid = 1'b0;
    chk("coin_valid", {31'd0, out_valid}, 32'd1);
    chk("coin_data", {16'd0, out_data}, 32'h8801);
    drain();
    push_result(16'h7701, 16'h7702, 16'h7703);
    push_result(16'h8801, 16'h8802, 16'h8803);
    check_stream("coin");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
